// File: rtl/fifo_uart_tx.sv
// Drains a first-word-fall-through fifo and serialises each byte as one UART frame on txd.
// Default build is 8N1; define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module fifo_uart_tx #(
    parameter int BAUD_DIV = 868,
    parameter int DIV_BITS = $clog2(BAUD_DIV)   // derived, leave at default
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_r,
    output logic       txd,
    output logic       busy
);

    localparam logic [DIV_BITS-1:0] LAST_TICK = DIV_BITS'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_BITS-1:0] timer_q, timer_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                txd_q, txd_d;
    logic                fifo_r_q, fifo_r_d;
    logic                busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    logic bit_done;
    logic can_pop;

    assign bit_done = (timer_q == LAST_TICK);
    assign can_pop  = en & ~fifo_empty;

    // txd is registered from the current state, so the line lags the state by
    // one cycle: a pop in cycle N puts the start bit on txd at N+1.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        busy_d    = busy_q;
        fifo_r_d  = 1'b0;
        txd_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif

        if (state_q != IDLE) begin
            timer_d = bit_done ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                timer_d   = '0;
                bit_idx_d = '0;
                if (can_pop) begin
                    shift_d  = fifo_dout;
                    fifo_r_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = START;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_dout;
`endif
                end
            end
            START: begin
                txd_d = 1'b0;
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                txd_d = shift_q[0];
                if (bit_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txd_d = parity_q;
                if (bit_done) state_d = STOP;
            end
`endif
            STOP: begin
                txd_d = 1'b1;
                if (bit_done) begin
                    // Chain the next frame straight out of the stop bit: no idle gap.
                    if (can_pop) begin
                        shift_d  = fifo_dout;
                        fifo_r_d = 1'b1;
                        state_d  = START;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_dout;
`endif
                    end else begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: the shift register is reset too; it is a plain register, not a memory array.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
            fifo_r_q  <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
            fifo_r_q  <= fifo_r_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign txd    = txd_q;
    assign fifo_r = fifo_r_q;
    assign busy   = busy_q;

endmodule
